// File: rtl/gate3_arb_pkg.sv
// Shared encodings for the gate3 round-robin arbiter.
package gate3_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OP_AND  = 1'b0;
    localparam logic OP_OR   = 1'b1;
    localparam int   NUM_REQ = 3;
endpackage

// File: rtl/gate3_cells.sv
// Single-bit 3-input AND / OR cells used to build the shared gate arrays.
module and3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = a & b & c;
endmodule

module or3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = a | b | c;
endmodule

// File: rtl/gate3_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping mod 3.
module gate3_rr_pick
    import gate3_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [1:0]         win_idx
);
    logic [1:0] base;
    logic [2:0] sum;
    logic [1:0] cand;
    logic       found;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        // ptr never reaches 3; treat it as 0 so the picker stays total
        base    = (ptr == 2'd3) ? 2'd0 : ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, base} + 3'(i);
            if (sum >= 3'd3) sum = sum - 3'd3;
            cand = sum[1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                win[cand]   = 1'b1;
                win_idx     = cand;
            end
        end
    end
endmodule

// File: rtl/gate3_arbiter.sv
// Shares one WIDTH-bit AND3/OR3 unit among three requesters, round-robin, 3 cycles per job.
// Optional per-requester grant counters enabled by `define GATE3_ARB_PERF_EN.
module gate3_arbiter
    import gate3_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   op,
    input  logic [9*WIDTH-1:0]   opnd,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [WIDTH-1:0]     result,
    output logic                 busy
`ifdef GATE3_ARB_PERF_EN
    ,
    output logic [3*CNT_W-1:0]   grant_cnt
`endif
);
    state_e               state_q, state_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 op_l_q, op_l_d;
    logic [3*WIDTH-1:0]   opnd_l_q, opnd_l_d;

    logic [NUM_REQ-1:0]   win;
    logic [1:0]           win_idx;
    logic [3*WIDTH-1:0]   opnd_sel;
    logic                 op_sel;
    logic [WIDTH-1:0]     and_out, or_out;
    logic                 grant_edge;

    gate3_rr_pick u_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        opnd_sel = '0;
        op_sel   = 1'b0;
        case (win_idx)
            2'd0:    begin opnd_sel = opnd[0*3*WIDTH +: 3*WIDTH]; op_sel = op[0]; end
            2'd1:    begin opnd_sel = opnd[1*3*WIDTH +: 3*WIDTH]; op_sel = op[1]; end
            default: begin opnd_sel = opnd[2*3*WIDTH +: 3*WIDTH]; op_sel = op[2]; end
        endcase
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_gate
        and3 u_and (
            .a (opnd_l_q[b]),
            .b (opnd_l_q[WIDTH+b]),
            .c (opnd_l_q[2*WIDTH+b]),
            .y (and_out[b])
        );
        or3 u_or (
            .a (opnd_l_q[b]),
            .b (opnd_l_q[WIDTH+b]),
            .c (opnd_l_q[2*WIDTH+b]),
            .y (or_out[b])
        );
    end

    assign grant_edge = (state_q == ST_IDLE) && (|req);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        done_d   = 1'b0 ? done_q : '0;
        result_d = result_q;
        busy_d   = busy_q;
        op_l_d   = op_l_q;
        opnd_l_d = opnd_l_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_edge) begin
                    gnt_d    = win;
                    op_l_d   = op_sel;
                    opnd_l_d = opnd_sel;
                    busy_d   = 1'b1;
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                result_d = (op_l_q == OP_OR) ? or_out : and_out;
                done_d   = gnt_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                // pointer moves one past whoever was just served
                rr_ptr_d = gnt_q[0] ? 2'd1 : (gnt_q[1] ? 2'd2 : 2'd0);
                gnt_d    = '0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            op_l_q   <= 1'b0;
            opnd_l_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            op_l_q   <= op_l_d;
            opnd_l_q <= opnd_l_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign busy   = busy_q;

`ifdef GATE3_ARB_PERF_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_edge && win[k] && (cnt_q[k] != {CNT_W{1'b1}}))
                cnt_d[k] = cnt_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_gate3_arbiter.sv
// Directed + randomized bench for gate3_arbiter against a behavioural round-robin model.
module tb_gate3_arbiter;
    localparam int W  = 8;
    localparam int CW = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      req   = '0;
    logic [2:0]      op    = '0;
    logic [9*W-1:0]  opnd  = '0;
    logic [2:0]      gnt;
    logic [2:0]      done;
    logic [W-1:0]    result;
    logic            busy;
`ifdef GATE3_ARB_PERF_EN
    logic [3*CW-1:0] grant_cnt;
`endif

    int           vectors     = 0;
    int           miscompares = 0;
    int           ptr         = 0;
    int           cnt [3]     = '{0, 0, 0};
    logic [W-1:0] last_res    = '0;

    gate3_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .op     (op),
        .opnd   (opnd),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy)
`ifdef GATE3_ARB_PERF_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt();
`ifdef GATE3_ARB_PERF_EN
        for (int k = 0; k < 3; k++)
            check($sformatf("grant_cnt%0d", k), 32'(grant_cnt[k*CW +: CW]), 32'(cnt[k]));
`endif
    endtask

    function automatic logic [W-1:0] gate_ref(input bit o, input logic [W-1:0] a, b, c);
        return o ? (a | b | c) : (a & b & c);
    endfunction

    function automatic int pick(input logic [2:0] r);
        for (int i = 0; i < 3; i++) begin
            if (r[(ptr + i) % 3]) return (ptr + i) % 3;
        end
        return -1;
    endfunction

    function automatic logic [9*W-1:0] rand_opnd();
        logic [95:0] t = {$urandom, $urandom, $urandom};
        return t[9*W-1:0];
    endfunction

    task automatic model_reset();
        ptr      = 0;
        last_res = '0;
        for (int k = 0; k < 3; k++) cnt[k] = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},    32'(gnt),    32'h0);
        check({tag, "_done"},   32'(done),   32'h0);
        check({tag, "_result"}, 32'(result), 32'(last_res));
        check({tag, "_busy"},   32'(busy),   32'h0);
        check_cnt();
    endtask

    // Called just after an active edge with the DUT idle; covers one grant slot.
    task automatic txn(input logic [2:0] r, input logic [2:0] o, input logic [9*W-1:0] d,
                       input bit drop);
        int           w;
        logic [W-1:0] exp;
        req  = r;
        op   = o;
        opnd = d;
        w    = pick(r);
        @(posedge clk); #1;
        if (w < 0) begin
            check_idle_outputs("idle");
            return;
        end
        exp = gate_ref(o[w], d[(3*w)*W +: W], d[(3*w+1)*W +: W], d[(3*w+2)*W +: W]);
        if (cnt[w] < (1 << CW) - 1) cnt[w]++;
        check("eval_gnt",  32'(gnt),  32'(1 << w));
        check("eval_done", 32'(done), 32'h0);
        check("eval_busy", 32'(busy), 32'h1);
        check_cnt();
        req  = drop ? 3'b000 : 3'($urandom);
        op   = 3'($urandom);
        opnd = rand_opnd();
        @(posedge clk); #1;
        check("resp_gnt",    32'(gnt),    32'(1 << w));
        check("resp_done",   32'(done),   32'(1 << w));
        check("resp_result", 32'(result), 32'(exp));
        check("resp_busy",   32'(busy),   32'h1);
        last_res = exp;
        @(posedge clk); #1;
        check_idle_outputs("post");
        ptr = (w + 1) % 3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("reset");
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9*W-1:0] d;
        #1;
        model_reset();
        check_idle_outputs("por");
        #10;
        rst_n = 1'b1;

        // single AND from requester 0
        d = '0;
        d[0*W +: W] = 8'hF0;
        d[1*W +: W] = 8'hCC;
        d[2*W +: W] = 8'hAA;
        txn(3'b001, 3'b000, d, 1'b0);
        check("and_result_hold", 32'(result), 32'h80);

        txn(3'b000, 3'b000, rand_opnd(), 1'b0);

        // single OR from requester 2
        d = '0;
        d[6*W +: W] = 8'h01;
        d[7*W +: W] = 8'h02;
        d[8*W +: W] = 8'h04;
        txn(3'b100, 3'b100, d, 1'b0);
        check("or_result_hold", 32'(result), 32'h07);

        // requester 1 drops req and changes operands right after grant
        txn(3'b010, 3'($urandom), rand_opnd(), 1'b1);

        // reset asserted during EVAL
        req  = 3'b010;
        op   = 3'($urandom);
        opnd = rand_opnd();
        @(posedge clk); #1;
        check("mid_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("mid_rst");
        #2;
        rst_n = 1'b1;
        txn(3'b011, 3'($urandom), rand_opnd(), 1'b0);

        // saturation of requester 0's counter, then full rotation from reset
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 5; i++) txn(3'b001, 3'($urandom), rand_opnd(), 1'b0);
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 6; i++) txn(3'b111, 3'($urandom), rand_opnd(), 1'b0);

        for (int i = 0; i < 40; i++)
            txn(3'($urandom), 3'($urandom), rand_opnd(), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
